// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, runs the req/ack handshake to
// instruction memory and presents one instruction at a time to decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemAck,
  input  logic [31:0] ImemData,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        InstrValid,
  input  logic        Stall,
  input  logic        JumpBranch,
  input  logic        JumpTarget,
  input  logic        JumpReg,
  input  logic [31:0] RsData,
  output logic        Fault,
  output logic [31:0] RetireCount
);

  typedef enum logic [1:0] {S_RESET, S_FETCH, S_EXEC, S_HALT} state_t;

  state_t      state, stateNext;
  logic [31:0] pcNext, instrNext, retireNext;
  logic        faultNext;
  logic [31:0] pcPlus4, branchOff, jumpPc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_RESET;
      pc          <= RESET_PC;
      instr       <= '0;
      Fault       <= 1'b0;
      RetireCount <= '0;
    end else begin
      state       <= stateNext;
      pc          <= pcNext;
      instr       <= instrNext;
      Fault       <= faultNext;
      RetireCount <= retireNext;
    end
  end

  always_comb begin
    pcPlus4   = pc + 32'd4;
    branchOff = {{14{instr[15]}}, instr[15:0], 2'b00};
    if (JumpReg)
      jumpPc = RsData;
    else if (JumpTarget)
      jumpPc = {pcPlus4[31:28], instr[25:0], 2'b00};
    else if (JumpBranch)
      jumpPc = pcPlus4 + branchOff;
    else
      jumpPc = pcPlus4;
  end

  always_comb begin
    stateNext  = state;
    pcNext     = pc;
    instrNext  = instr;
    faultNext  = Fault;
    retireNext = RetireCount;
    case (state)
      S_RESET: stateNext = S_FETCH;
      S_FETCH: begin
        if (ImemAck) begin
          instrNext = ImemData;
          stateNext = S_EXEC;
        end
      end
      S_EXEC: begin
        // The faulting instruction still retires; pc stays on it for debug.
        if (!Stall) begin
          retireNext = RetireCount + 32'd1;
          if (jumpPc[1:0] != 2'b00) begin
            faultNext = 1'b1;
            stateNext = S_HALT;
          end else begin
            pcNext    = jumpPc;
            stateNext = S_FETCH;
          end
        end
      end
      S_HALT:  stateNext = S_HALT;
      default: stateNext = S_RESET;
    endcase
  end

  // Decoded from the state register so reset drops them asynchronously.
  assign ImemReq    = (state == S_FETCH);
  assign InstrValid = (state == S_EXEC);
  assign ImemAddr   = pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// instruction streams against a behavioural next-PC / retire model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemAck;
  logic [31:0] ImemData;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        InstrValid;
  logic        Stall;
  logic        JumpBranch;
  logic        JumpTarget;
  logic        JumpReg;
  logic [31:0] RsData;
  logic        Fault;
  logic [31:0] RetireCount;

  int nChecks = 0;
  int nFail   = 0;

  logic [31:0] mPc;
  logic [31:0] mInstr;
  logic [31:0] mRetire;
  logic        mFault;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .ImemReq(ImemReq), .ImemAddr(ImemAddr),
    .ImemAck(ImemAck), .ImemData(ImemData), .instr(instr), .pc(pc),
    .InstrValid(InstrValid), .Stall(Stall), .JumpBranch(JumpBranch),
    .JumpTarget(JumpTarget), .JumpReg(JumpReg), .RsData(RsData),
    .Fault(Fault), .RetireCount(RetireCount)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Architectural next-PC rule expressed with plain arithmetic.
  function automatic logic [31:0] refNext(input logic [31:0] p, input logic [31:0] ins,
                                          input logic jr, input logic jt, input logic jb,
                                          input logic [31:0] rs);
    logic [31:0] seq;
    seq = p + 32'd4;
    if (jr) return rs;
    if (jt) return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 32'd4);
    if (jb) return seq + 32'($signed(ins[15:0])) * 32'd4;
    return seq;
  endfunction

  task automatic clearJumps();
    JumpReg = 1'b0; JumpTarget = 1'b0; JumpBranch = 1'b0;
  endtask

  task automatic doReset();
    rst_n = 1'b0; ImemAck = 1'b0; Stall = 1'b0; RsData = '0;
    clearJumps();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mPc = 32'h0; mInstr = '0; mRetire = '0; mFault = 1'b0;
  endtask

  // Serves one fetch; jump inputs carry noise while the fetch is pending.
  task automatic fetchOne(input int waits, input logic [31:0] data, output int reqCycles,
                          output logic [31:0] addr, output logic stable, output logic ok);
    ok = 1'b0; reqCycles = 0; stable = 1'b1; addr = '0;
    for (int i = 0; i < 50 && !ImemReq; i++) @(negedge clk);
    if (!ImemReq) return;
    addr = ImemAddr;
    reqCycles = 1;
    for (int i = 0; i < waits; i++) begin
      ImemAck = 1'b0;
      JumpReg = 1'($urandom); JumpTarget = 1'($urandom); JumpBranch = 1'($urandom);
      RsData = $urandom;
      @(negedge clk);
      if (ImemReq && ImemAddr == addr && !InstrValid) reqCycles++;
      else stable = 1'b0;
    end
    ImemAck = 1'b1; ImemData = data;
    @(negedge clk);
    ImemAck = 1'b0; ImemData = $urandom;
    clearJumps();
    mInstr = data;
    ok = 1'b1;
  endtask

  task automatic execOne(input logic jr, input logic jt, input logic jb, input logic [31:0] rs);
    logic [31:0] nxt;
    JumpReg = jr; JumpTarget = jt; JumpBranch = jb; RsData = rs; Stall = 1'b0;
    nxt = refNext(mPc, mInstr, jr, jt, jb, rs);
    mRetire = mRetire + 32'd1;
    if (nxt[1:0] != 2'b00) mFault = 1'b1;
    else mPc = nxt;
    @(negedge clk);
    clearJumps();
  endtask

  task automatic gotoPc(input logic [31:0] target);
    int rc; logic [31:0] a; logic st, ok;
    fetchOne(0, $urandom, rc, a, st, ok);
    execOne(1'b1, 1'b0, 1'b0, target);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    nChecks++; if (ImemReq !== 1'b0) begin nFail++; $display("FAIL reset_req: got %b want 0", ImemReq); end
    nChecks++; if (InstrValid !== 1'b0) begin nFail++; $display("FAIL reset_valid: got %b want 0", InstrValid); end
    nChecks++; if (pc !== 32'h0) begin nFail++; $display("FAIL reset_pc: got %h want 0", pc); end
    nChecks++; if (ImemAddr !== 32'h0) begin nFail++; $display("FAIL reset_addr: got %h want 0", ImemAddr); end
    nChecks++; if (instr !== 32'h0) begin nFail++; $display("FAIL reset_instr: got %h want 0", instr); end
    nChecks++; if (Fault !== 1'b0) begin nFail++; $display("FAIL reset_fault: got %b want 0", Fault); end
    nChecks++; if (RetireCount !== 32'h0) begin nFail++; $display("FAIL reset_retire: got %0d want 0", RetireCount); end
  endtask

  task automatic test_sequential();
    int rc; logic [31:0] a, d; logic st, ok;
    doReset();
    for (int k = 0; k < 3; k++) begin
      d = $urandom;
      fetchOne(0, d, rc, a, st, ok);
      nChecks++; if (!ok || a !== 32'(4 * k)) begin nFail++; $display("FAIL seq_addr%0d: got %h want %h", k, a, 32'(4 * k)); end
      nChecks++; if (InstrValid !== 1'b1 || instr !== d) begin nFail++; $display("FAIL seq_exec%0d: valid %b instr %h want 1 %h", k, InstrValid, instr, d); end
      execOne(1'b0, 1'b0, 1'b0, 32'h0);
      nChecks++; if (InstrValid !== 1'b0 || ImemReq !== 1'b1) begin nFail++; $display("FAIL seq_refetch%0d: valid %b req %b want 0 1", k, InstrValid, ImemReq); end
    end
    nChecks++; if (RetireCount !== 32'd3) begin nFail++; $display("FAIL seq_retire: got %0d want 3", RetireCount); end
  endtask

  task automatic test_wait_states();
    int rc; logic [31:0] a, d; logic st, ok;
    d = $urandom;
    fetchOne(3, d, rc, a, st, ok);
    nChecks++; if (!ok || !st || rc != 4) begin nFail++; $display("FAIL wait_hold: reqCycles %0d stable %b want 4 1", rc, st); end
    nChecks++; if (a !== mPc) begin nFail++; $display("FAIL wait_addr: got %h want %h", a, mPc); end
    nChecks++; if (InstrValid !== 1'b1 || instr !== d) begin nFail++; $display("FAIL wait_capture: valid %b instr %h want 1 %h", InstrValid, instr, d); end
    execOne(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_branch();
    int rc; logic [31:0] a, d; logic st, ok;
    d = {16'($urandom), 16'hFFFC};
    gotoPc(32'h10);
    fetchOne(0, d, rc, a, st, ok);
    nChecks++; if (pc !== 32'h10) begin nFail++; $display("FAIL br_pc: got %h want 10", pc); end
    execOne(1'b0, 1'b0, 1'b1, 32'h0);
    nChecks++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h4) begin nFail++; $display("FAIL br_taken: got %h want 4", ImemAddr); end
    gotoPc(32'h10);
    fetchOne(0, d, rc, a, st, ok);
    execOne(1'b0, 1'b0, 1'b0, 32'h0);
    nChecks++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h14) begin nFail++; $display("FAIL br_not_taken: got %h want 14", ImemAddr); end
  endtask

  task automatic test_jump();
    int rc; logic [31:0] a, d; logic st, ok;
    d = {6'($urandom), 26'h000_0100};
    gotoPc(32'h4000_0010);
    fetchOne(0, d, rc, a, st, ok);
    execOne(1'b0, 1'b1, 1'b0, 32'h0);
    nChecks++; if (ImemAddr !== 32'h4000_0400) begin nFail++; $display("FAIL jump_target: got %h want 40000400", ImemAddr); end
    gotoPc(32'h4000_0010);
    fetchOne(0, d, rc, a, st, ok);
    execOne(1'b1, 1'b1, 1'b1, 32'h200);
    nChecks++; if (ImemAddr !== 32'h200) begin nFail++; $display("FAIL jump_priority: got %h want 200", ImemAddr); end
    gotoPc(32'hFFFF_FFFC);
    fetchOne(0, $urandom, rc, a, st, ok);
    execOne(1'b0, 1'b0, 1'b0, 32'h0);
    nChecks++; if (ImemAddr !== 32'h0) begin nFail++; $display("FAIL pc_wrap: got %h want 0", ImemAddr); end
  endtask

  task automatic test_random();
    int rc; logic [31:0] a, d, p0; logic st, ok;
    for (int n = 0; n < 40; n++) begin
      d = $urandom;
      fetchOne(int'($urandom_range(0, 3)), d, rc, a, st, ok);
      nChecks++; if (!ok || a !== mPc || instr !== d) begin nFail++; $display("FAIL rand_fetch%0d: addr %h instr %h want %h %h", n, a, instr, mPc, d); end
      p0 = pc;
      for (int s = 0; s < int'($urandom_range(0, 2)); s++) begin
        Stall = 1'b1;
        JumpReg = 1'($urandom); JumpTarget = 1'($urandom); JumpBranch = 1'($urandom);
        @(negedge clk);
      end
      Stall = 1'b0;
      nChecks++; if (InstrValid !== 1'b1 || pc !== p0) begin nFail++; $display("FAIL rand_stall%0d: valid %b pc %h want 1 %h", n, InstrValid, pc, p0); end
      execOne(1'($urandom), 1'($urandom), 1'($urandom), $urandom & 32'hFFFF_FFFC);
      nChecks++; if (RetireCount !== mRetire) begin nFail++; $display("FAIL rand_retire%0d: got %0d want %0d", n, RetireCount, mRetire); end
    end
  endtask

  task automatic test_stall_misalign();
    int rc; logic [31:0] a, d, p0, r0; logic st, ok;
    d = $urandom;
    fetchOne(1, d, rc, a, st, ok);
    p0 = mPc; r0 = mRetire;
    for (int s = 0; s < 5; s++) begin
      Stall = 1'b1;
      JumpReg = 1'($urandom); JumpTarget = 1'($urandom); JumpBranch = 1'($urandom);
      RsData = $urandom;
      @(negedge clk);
      nChecks++;
      if (instr !== d || pc !== p0 || InstrValid !== 1'b1 || RetireCount !== r0) begin
        nFail++;
        $display("FAIL stall_hold%0d: instr %h pc %h valid %b retire %0d want %h %h 1 %0d",
                 s, instr, pc, InstrValid, RetireCount, d, p0, r0);
      end
    end
    execOne(1'b1, 1'b0, 1'b0, 32'h202);
    nChecks++; if (Fault !== 1'b1 || Fault !== mFault) begin nFail++; $display("FAIL misalign_fault: got %b want 1", Fault); end
    nChecks++; if (ImemReq !== 1'b0 || InstrValid !== 1'b0) begin nFail++; $display("FAIL misalign_idle: req %b valid %b want 0 0", ImemReq, InstrValid); end
    nChecks++; if (RetireCount !== r0 + 32'd1) begin nFail++; $display("FAIL misalign_retire: got %0d want %0d", RetireCount, r0 + 32'd1); end
    nChecks++; if (pc !== p0) begin nFail++; $display("FAIL misalign_pc: got %h want %h", pc, p0); end
    ImemAck = 1'b1;
    repeat (3) @(negedge clk);
    ImemAck = 1'b0;
    nChecks++; if (Fault !== 1'b1 || ImemReq !== 1'b0 || InstrValid !== 1'b0) begin nFail++; $display("FAIL halt_sticky: fault %b req %b valid %b want 1 0 0", Fault, ImemReq, InstrValid); end
  endtask

  task automatic test_reset_midfetch();
    int rc; logic [31:0] a; logic st, ok;
    doReset();
    fetchOne(0, $urandom, rc, a, st, ok);
    execOne(1'b0, 1'b0, 1'b0, 32'h0);
    nChecks++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h4) begin nFail++; $display("FAIL mid_prefetch: req %b addr %h want 1 4", ImemReq, ImemAddr); end
    #2 rst_n = 1'b0;
    #1;
    nChecks++; if (ImemReq !== 1'b0 || ImemAddr !== 32'h0) begin nFail++; $display("FAIL mid_async: req %b addr %h want 0 0", ImemReq, ImemAddr); end
    ImemAck = 1'b1; ImemData = 32'hDEAD_BEEF;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ImemAck = 1'b0;
    nChecks++; if (InstrValid !== 1'b0 || instr !== 32'h0) begin nFail++; $display("FAIL mid_ack_ignored: valid %b instr %h want 0 0", InstrValid, instr); end
    nChecks++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h0) begin nFail++; $display("FAIL mid_restart: req %b addr %h want 1 0", ImemReq, ImemAddr); end
    nChecks++; if (Fault !== 1'b0 || RetireCount !== 32'h0) begin nFail++; $display("FAIL mid_clear: fault %b retire %0d want 0 0", Fault, RetireCount); end
  endtask

  initial begin
    rst_n = 1'b1; ImemAck = 1'b0; ImemData = '0; Stall = 1'b0; RsData = '0;
    clearJumps();
    mPc = '0; mInstr = '0; mRetire = '0; mFault = 1'b0;
    test_reset();
    test_sequential();
    test_wait_states();
    test_branch();
    test_jump();
    test_random();
    test_stall_misalign();
    test_reset_midfetch();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
